// File: rtl/channel_crossfader_if.sv
// Sample/control bus of the channel crossfader: per-channel samples, offsets
// and gains in, one mixed sample plus status out.
interface channel_crossfader_if #(
  parameter int N_CH   = 2,
  parameter int DATA_W = 11,
  parameter int GAIN_W = 12
);
  localparam int SEL_W = $clog2(N_CH);

  logic                       enable_3M;
  logic [SEL_W-1:0]           sel;
  logic [N_CH*DATA_W-1:0]     data_in;
  logic [N_CH*DATA_W-1:0]     offset;
  logic [N_CH*GAIN_W-1:0]     gain;
  logic signed [DATA_W-1:0]   data_out;
  logic                       data_valid;
  logic [SEL_W-1:0]           active_ch;
  logic                       fading;

  // Producer of samples / consumer of the mixed output.
  modport master (
    output enable_3M, sel, data_in, offset, gain,
    input  data_out, data_valid, active_ch, fading
  );

  // The crossfader itself.
  modport slave (
    input  enable_3M, sel, data_in, offset, gain,
    output data_out, data_valid, active_ch, fading
  );
endinterface

// File: rtl/channel_crossfader.sv
// Channel crossfader: per-channel offset/gain correction with saturation
// (stage 1), followed by a linear crossfade between the active channel and a
// newly selected target over 2^XFADE_LOG2 samples (stage 2).
module channel_crossfader #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 11,
  parameter int GAIN_W     = 12,
  parameter int XFADE_LOG2 = 4
) (
  input  logic             clk,
  input  logic             reset,
  channel_crossfader_if.slave bus
);
  localparam int SEL_W  = $clog2(N_CH);
  localparam int SEL_W1 = SEL_W + 1;
  localparam int KW     = XFADE_LOG2 + 1;
  localparam int ACC_W  = DATA_W + XFADE_LOG2 + 1;
  localparam int PROD_W = DATA_W + GAIN_W + 2;
  localparam int SH     = GAIN_W - 2;

  localparam logic [SEL_W:0]              N_CH_EXT  = SEL_W1'(N_CH);
  localparam logic [KW-1:0]               K_FULL    = KW'(2 ** XFADE_LOG2);
  localparam logic signed [ACC_W-1:0]     FULL_ACC  = ACC_W'(2 ** XFADE_LOG2);
  localparam logic signed [PROD_W-1:0]    SAT_MAX   = PROD_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [PROD_W-1:0]    SAT_MIN   = ~SAT_MAX;

  typedef enum logic {S_IDLE, S_FADE} state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: correction of every channel
  // ---------------------------------------------------------------------------
  logic signed [DATA_W-1:0] y_corr [N_CH];
  logic signed [DATA_W-1:0] y1_reg [N_CH];
  logic [SEL_W-1:0]         sel1_reg;
  logic                     v1_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_corr
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] off_s;
    logic signed [DATA_W:0]   diff_s;
    logic signed [GAIN_W:0]   gain_s;
    logic signed [PROD_W-1:0] prod_s;
    logic signed [PROD_W-1:0] shr_s;

    assign x_s    = bus.data_in[gi*DATA_W +: DATA_W];
    assign off_s  = bus.offset[gi*DATA_W +: DATA_W];
    // One extra bit so the difference of two full-scale samples cannot wrap.
    assign diff_s = {x_s[DATA_W-1], x_s} - {off_s[DATA_W-1], off_s};
    assign gain_s = {1'b0, bus.gain[gi*GAIN_W +: GAIN_W]};
    assign prod_s = PROD_W'(diff_s) * PROD_W'(gain_s);
    // Arithmetic shift floors toward minus infinity.
    assign shr_s  = prod_s >>> SH;
    assign y_corr[gi] = (shr_s > SAT_MAX) ? DATA_W'(SAT_MAX) :
                        (shr_s < SAT_MIN) ? DATA_W'(SAT_MIN) :
                                            DATA_W'(shr_s);
  end

  // Capture corrected samples and the requested channel on each strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg   <= 1'b0;
      sel1_reg <= '0;
      for (int i = 0; i < N_CH; i++) y1_reg[i] <= '0;
    end else begin
      v1_reg <= bus.enable_3M;
      if (bus.enable_3M) begin
        sel1_reg <= bus.sel;
        for (int i = 0; i < N_CH; i++) y1_reg[i] <= y_corr[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: crossfade state machine and output register
  // ---------------------------------------------------------------------------
  state_t                   state_reg, state_next;
  logic [KW-1:0]            k_reg, k_next;
  logic [KW-1:0]            k_inc;
  logic [SEL_W-1:0]         tgt_reg, tgt_next;
  logic [SEL_W-1:0]         active_reg, active_next;
  logic signed [DATA_W-1:0] data_out_reg, data_out_next;
  logic                     valid_reg, valid_next;
  logic                     fading_reg, fading_next;
  logic                     sel_oor;

  assign sel_oor = ({1'b0, sel1_reg} >= N_CH_EXT);

  // Weighted mix of the outgoing and incoming channel; weights sum to 2^K so
  // the result always stays inside the span of the two saturated operands.
  function automatic logic signed [DATA_W-1:0] xfade_mix(
    input logic signed [DATA_W-1:0] ya,
    input logic signed [DATA_W-1:0] yt,
    input logic [KW-1:0]            kk
  );
    logic signed [ACC_W-1:0] a_ext, t_ext, w_t, w_a, acc;
    a_ext = {{(ACC_W-DATA_W){ya[DATA_W-1]}}, ya};
    t_ext = {{(ACC_W-DATA_W){yt[DATA_W-1]}}, yt};
    w_t   = {{(ACC_W-KW){1'b0}}, kk};
    w_a   = FULL_ACC - w_t;
    acc   = a_ext * w_a + t_ext * w_t;
    return DATA_W'(acc >>> XFADE_LOG2);
  endfunction

  // State, fade counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      k_reg        <= '0;
      tgt_reg      <= '0;
      active_reg   <= '0;
      data_out_reg <= '0;
      valid_reg    <= 1'b0;
      fading_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      tgt_reg      <= tgt_next;
      active_reg   <= active_next;
      data_out_reg <= data_out_next;
      valid_reg    <= valid_next;
      fading_reg   <= fading_next;
    end
  end

  // Next-state and output decision for each corrected sample.
  always_comb begin
    state_next    = state_reg;
    k_next        = k_reg;
    tgt_next      = tgt_reg;
    active_next   = active_reg;
    data_out_next = data_out_reg;
    valid_next    = 1'b0;
    fading_next   = fading_reg;
    k_inc         = k_reg + KW'(1);

    case (state_reg)
      S_IDLE: begin
        if (v1_reg) begin
          valid_next = 1'b1;
          if ((sel1_reg == active_reg) || sel_oor) begin
            data_out_next = y1_reg[active_reg];
            fading_next   = 1'b0;
          end else begin
            // First fade sample is emitted immediately with k = 1.
            tgt_next      = sel1_reg;
            k_next        = KW'(1);
            state_next    = S_FADE;
            data_out_next = xfade_mix(y1_reg[active_reg], y1_reg[sel1_reg], KW'(1));
            fading_next   = 1'b1;
          end
        end
      end
      S_FADE: begin
        // sel is ignored here; a pending change is picked up back in IDLE.
        if (v1_reg) begin
          valid_next = 1'b1;
          if (k_inc == K_FULL) begin
            data_out_next = y1_reg[tgt_reg];
            active_next   = tgt_reg;
            k_next        = '0;
            state_next    = S_IDLE;
            fading_next   = 1'b0;
          end else begin
            data_out_next = xfade_mix(y1_reg[active_reg], y1_reg[tgt_reg], k_inc);
            k_next        = k_inc;
            fading_next   = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign bus.data_out   = data_out_reg;
  assign bus.data_valid = valid_reg;
  assign bus.active_ch  = active_reg;
  assign bus.fading     = fading_reg;
endmodule
